// File: rtl/xmbox.sv
// Memory-mapped mailbox: CPU-written TX FIFO drained by a stream sink, externally filled RX FIFO read by the CPU.
// Optional build macro XMBOX_IRQ_EN adds a registered irq output and the CTRL irq_mask bit.
module xmbox #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'h100,
    parameter int                DEPTH_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sel,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_push,
    input  logic [DATA_W-1:0] rx_data
`ifdef XMBOX_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    logic [DATA_W-1:0]     r_tx_mem [DEPTH];
    logic [DATA_W-1:0]     r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [DEPTH_LOG2:0]   r_tx_cnt, r_rx_cnt;
    logic                  r_rx_ovf;
    logic                  r_en;
`ifdef XMBOX_IRQ_EN
    logic                  r_irq_mask;
    logic                  r_irq;
`endif

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr, w_rd;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_drop;
    logic        w_ctrl_wr, w_flush, w_ovf_clr;
    logic [DATA_W-1:0] w_status, w_ctrl;

    assign w_hit = data_sel & (data_addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
    assign w_off = data_addr[1:0];
    assign w_wr  = w_hit & data_we;
    assign w_rd  = w_hit & ~data_we;

    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);

    assign tx_valid = r_en & ~w_tx_empty;
    assign tx_data  = r_tx_mem[r_tx_rd];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_tx_push = w_wr & (w_off == 2'd0) & (~w_tx_full | w_tx_pop);
    assign w_rx_pop  = w_rd & (w_off == 2'd1) & ~w_rx_empty;
    assign w_rx_push = rx_push & r_en & (~w_rx_full | w_rx_pop);
    assign w_rx_drop = rx_push & r_en & w_rx_full & ~w_rx_pop;

    assign w_ctrl_wr = w_wr & (w_off == 2'd3);
    assign w_flush   = w_ctrl_wr & data_to_wr[1];
    assign w_ovf_clr = w_wr & (w_off == 2'd2) & data_to_wr[4];

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= data_to_wr;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovf <= 1'b0;
        end else if (w_flush) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            // A fresh overflow in the clearing cycle wins so the event is not lost.
            if (w_rx_drop)      r_rx_ovf <= 1'b1;
            else if (w_ovf_clr) r_rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= 1'b0;
`ifdef XMBOX_IRQ_EN
            r_irq_mask <= 1'b0;
`endif
        end else if (w_ctrl_wr) begin
            r_en <= data_to_wr[0];
`ifdef XMBOX_IRQ_EN
            r_irq_mask <= data_to_wr[2];
`endif
        end
    end

`ifdef XMBOX_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= r_irq_mask & r_en & (~w_rx_empty | r_rx_ovf);
    end
    assign irq = r_irq;
`endif

    always_comb begin
        w_status    = '0;
        w_status[0] = w_tx_full;
        w_status[1] = w_tx_empty;
        w_status[2] = w_rx_full;
        w_status[3] = w_rx_empty;
        w_status[4] = r_rx_ovf;
        w_status[8 +: DEPTH_LOG2+1] = r_rx_cnt;
    end

    always_comb begin
        w_ctrl    = '0;
        w_ctrl[0] = r_en;
`ifdef XMBOX_IRQ_EN
        w_ctrl[2] = r_irq_mask;
`endif
    end

    always_comb begin
        data_to_rd = '0;
        if (w_rd) begin
            case (w_off)
                2'd1:    data_to_rd = w_rx_empty ? '0 : r_rx_mem[r_rx_rd];
                2'd2:    data_to_rd = w_status;
                2'd3:    data_to_rd = w_ctrl;
                default: data_to_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xmbox.sv
// Directed bench for xmbox: register map, FIFO boundaries, flush and (with XMBOX_IRQ_EN) the interrupt.
module tb_xmbox;

    localparam logic [11:0] A_TX   = 12'h100;
    localparam logic [11:0] A_RX   = 12'h101;
    localparam logic [11:0] A_STAT = 12'h102;
    localparam logic [11:0] A_CTRL = 12'h103;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sel = 1'b0;
    logic        data_we = 1'b0;
    logic [11:0] data_addr = '0;
    logic [31:0] data_to_wr = '0;
    logic [31:0] data_to_rd;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        rx_push = 1'b0;
    logic [31:0] rx_data = '0;
`ifdef XMBOX_IRQ_EN
    logic        irq;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] rd;

    xmbox #(.DATA_W(32), .ADDR_W(12), .BASE_ADDR(12'h100), .DEPTH_LOG2(3)) dut (
        .clk(clk), .rst(rst),
        .data_sel(data_sel), .data_we(data_we), .data_addr(data_addr),
        .data_to_wr(data_to_wr), .data_to_rd(data_to_rd),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_push(rx_push), .rx_data(rx_data)
`ifdef XMBOX_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        data_sel = 1'b1; data_we = 1'b1; data_addr = a; data_to_wr = d;
        @(posedge clk); #1;
        data_sel = 1'b0; data_we = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        data_sel = 1'b1; data_we = 1'b0; data_addr = a;
        #1 d = data_to_rd;
        @(posedge clk); #1;
        data_sel = 1'b0;
    endtask

    task automatic ext_push(input logic [31:0] d);
        @(negedge clk);
        rx_push = 1'b1; rx_data = d;
        @(posedge clk); #1;
        rx_push = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_rd_idle", data_to_rd, 32'd0);
        bus_read(A_STAT, rd);  check("rst_status", rd, 32'h0000000A);
        bus_read(A_CTRL, rd);  check("rst_ctrl", rd, 32'd0);

        // TX basic
        bus_write(A_CTRL, 32'd1);
        bus_write(A_TX, 32'h11);
        check("tx1_valid", {31'd0, tx_valid}, 32'd1);
        check("tx1_data", tx_data, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_read(A_TX, rd);    check("txdata_reads0", rd, 32'd0);
        bus_read(A_STAT, rd);  check("tx2_status", rd, 32'h00000008);
        @(negedge clk) tx_ready = 1'b1;
        check("drain0", tx_data, 32'h11);
        @(negedge clk);
        check("drain1", tx_data, 32'h22);
        check("drain1_v", {31'd0, tx_valid}, 32'd1);
        @(negedge clk) tx_ready = 1'b0;
        check("drained_v", {31'd0, tx_valid}, 32'd0);

        // RX overflow
        for (int i = 1; i <= 9; i++) ext_push(i);
        bus_read(A_STAT, rd);  check("rx_ovf_status", rd, 32'h00000816);
        for (int i = 1; i <= 8; i++) begin
            bus_read(A_RX, rd); check($sformatf("rx_read%0d", i), rd, i);
        end
        bus_read(A_RX, rd);    check("rx_read_empty", rd, 32'd0);
        bus_read(A_STAT, rd);  check("rx_empty_ovf", rd, 32'h0000001A);
        bus_write(A_STAT, 32'h10);
        bus_read(A_STAT, rd);  check("ovf_cleared", rd, 32'h0000000A);

        // RX full with simultaneous read and push
        for (int i = 0; i < 8; i++) ext_push(32'h100 + i);
        @(negedge clk);
        data_sel = 1'b1; data_we = 1'b0; data_addr = A_RX;
        rx_push = 1'b1; rx_data = 32'hAB;
        #1 rd = data_to_rd;
        @(posedge clk); #1;
        data_sel = 1'b0; rx_push = 1'b0;
        check("full_rdpush_head", rd, 32'h100);
        bus_read(A_STAT, rd);  check("full_rdpush_status", rd, 32'h00000806);
        for (int i = 1; i < 8; i++) begin
            bus_read(A_RX, rd); check($sformatf("rx_wrap%0d", i), rd, 32'h100 + i);
        end
        bus_read(A_RX, rd);    check("rx_last_ab", rd, 32'hAB);

        // Flush
        for (int i = 0; i < 3; i++) bus_write(A_TX, 32'h30 + i);
        ext_push(32'h41);
        ext_push(32'h42);
        bus_read(A_STAT, rd);  check("pre_flush_status", rd, 32'h00000200);
        bus_write(A_CTRL, 32'd3);
        bus_read(A_STAT, rd);  check("flush_status", rd, 32'h0000000A);
        bus_read(A_CTRL, rd);  check("flush_ctrl", rd, 32'd1);
        check("flush_tx_valid", {31'd0, tx_valid}, 32'd0);

        // TX full: 9th word dropped
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'hA0 + i);
        bus_read(A_STAT, rd);  check("tx_full_status", rd, 32'h00000009);
        @(negedge clk) tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("txf_data%0d", i), tx_data, 32'hA0 + i);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("txf_drained", {31'd0, tx_valid}, 32'd0);

        // Disabled: no tx_valid, rx_push ignored
        bus_write(A_CTRL, 32'd0);
        bus_write(A_TX, 32'h55);
        check("dis_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("dis_tx_data", tx_data, 32'h55);
        ext_push(32'h66);
        bus_read(A_STAT, rd);  check("dis_status", rd, 32'h00000008);
        bus_write(A_CTRL, 32'd1);
        check("en_tx_valid", {31'd0, tx_valid}, 32'd1);
        @(negedge clk) tx_ready = 1'b1;
        @(negedge clk) tx_ready = 1'b0;
        check("en_drained", {31'd0, tx_valid}, 32'd0);

`ifdef XMBOX_IRQ_EN
        bus_write(A_CTRL, 32'd5);
        bus_read(A_CTRL, rd);  check("irq_ctrl", rd, 32'd5);
        check("irq_idle", {31'd0, irq}, 32'd0);
        ext_push(32'h77);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_set", {31'd0, irq}, 32'd1);
        bus_read(A_RX, rd);    check("irq_rx", rd, 32'h77);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        check("irq_clr", {31'd0, irq}, 32'd0);
        bus_write(A_CTRL, 32'd1);
        ext_push(32'h78);
        repeat (2) @(posedge clk);
        #1 check("irq_masked", {31'd0, irq}, 32'd0);
`else
        bus_write(A_CTRL, 32'd5);
        bus_read(A_CTRL, rd);  check("ctrl_no_mask", rd, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/xmbox.md
Name: xmbox

Overview:
- Memory-mapped mailbox peripheral that acts as the responder on the controller's data bus (data_sel / data_we / data_addr / data_to_wr / data_to_rd).
- Contains two FIFOs:
  - TX FIFO: the CPU writes words into it and an external stream sink drains them.
  - RX FIFO: an external source pushes words into it and the CPU reads them out.
- Read data is returned combinationally in the same cycle, because the controller latches data_to_rd at the clock edge ending the access.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 12, data bus address width.
- BASE_ADDR, 12'h100, first of 4 consecutive word addresses decoded by this block.
- DEPTH_LOG2, 3, log2 of each FIFO depth (DEPTH = 8 by default).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- data_sel  in  1  bus access strobe.
- data_we  in  1  1 = write, 0 = read; qualified by data_sel.
- data_addr  in  ADDR_W  word address.
- data_to_wr  in  DATA_W  write data from the controller.
- data_to_rd  out  DATA_W  read data to the controller; combinational.
- tx_valid  out  1  TX FIFO head is available.
- tx_ready  in  1  sink accepts the head word.
- tx_data  out  DATA_W  TX FIFO head word.
- rx_push  in  1  external word strobe; no backpressure.
- rx_data  in  DATA_W  external word.
- irq  out  1  only present with XMBOX_IRQ_EN.

Behaviour:
- Decode: hit = data_sel & (data_addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]). Offset = data_addr[1:0].
- Register map:
  - Offset 0, TXDATA. Write pushes data_to_wr into the TX FIFO. Read returns 0.
  - Offset 1, RXDATA. Read returns the RX head and pops it at the clock edge. Write is ignored.
  - Offset 2, STATUS (read):
    - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 rx_ovf (sticky).
    - [8+DEPTH_LOG2:8] rx_count. All other bits 0.
    - Writing 1 to bit4 clears rx_ovf. Other written bits are ignored.
  - Offset 3, CTRL (R/W):
    - bit0 en, bit2 irq_mask.
    - bit1 flush: self-clearing, always reads 0.
- data_to_rd = 0 when there is no hit or data_we=1.
- Reset:
  - Both FIFOs empty: pointers 0, counts 0.
  - rx_ovf=0, en=0, irq_mask=0.
  - tx_valid=0, data_to_rd=0, irq=0.
  - Reset mid-transfer discards all FIFO contents.
- FIFOs:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo DEPTH, plus a count register of DEPTH_LOG2+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- TX push: hit & data_we & offset 0.
  - Accepted if !tx_full, or if a TX pop occurs in the same cycle.
  - Otherwise the word is silently dropped.
- TX pop: tx_valid & tx_ready. tx_valid = en & !tx_empty. tx_data = mem[rd_ptr], valid regardless of en.
- RX push: rx_push & en.
  - Accepted if !rx_full, or if a CPU RXDATA read pops in the same cycle.
  - Otherwise the word is dropped and rx_ovf is set at that edge.
  - rx_push while en=0 is ignored; no overflow is flagged.
- RX pop: hit & !data_we & offset 1 & !rx_empty. A read when empty returns 0 and pops nothing.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- Flush (CTRL write with bit1=1):
  - At that edge, both FIFOs are emptied and rx_ovf is cleared.
  - Takes priority over any push or pop in the same cycle.
  - en and irq_mask take the newly written values.
- Latency:
  - A word written to TXDATA appears on tx_valid/tx_data the cycle after the write edge.
  - An rx_push word is visible in RXDATA/STATUS the cycle after its edge.
- Status flags and counts are registered state. They reflect the updates of the previous edge only.

Optional Feature:
- XMBOX_IRQ_EN.
- When defined:
  - irq output is present.
  - irq = registered (irq_mask & en & (!rx_empty | rx_ovf)), updated every edge. irq is 0 in reset.
- When undefined:
  - No irq port.
  - CTRL bit2 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read STATUS -> 0x0000000A (tx_empty, rx_empty). tx_valid=0.
- Write CTRL=1. Write TXDATA 0x11, 0x22 with tx_ready=0 -> tx_valid=1, tx_data=0x11. Raise tx_ready for 2 cycles -> 0x11 then 0x22 drained, tx_valid=0.
- en=1, rx_push 9 words 1..9 into DEPTH=8 -> STATUS rx_full=1, rx_ovf=1, rx_count=8. Eight RXDATA reads return 1..8. A 9th read returns 0. Write STATUS bit4 -> rx_ovf=0.
- RX full, and in the same cycle RXDATA read plus rx_push 0xAB -> read returns the old head, count stays 8, rx_ovf stays 0, 0xAB is the last word out.
- Fill TX with 3 words and RX with 2, then write CTRL=3 -> next cycle STATUS = tx_empty|rx_empty, CTRL reads 1, tx_valid=0.
- With XMBOX_IRQ_EN, CTRL=5, one rx_push -> irq=1 one cycle later. Read RXDATA -> irq=0 on the following cycle. With CTRL=1, irq stays 0.
